nand_serial_comparator: RTL and testbench
=========================================

Name: nand_serial_comparator

Overview:
- Cascadable 1-bit magnitude-comparator slice built only from NAND-based primitives: nand_not, nand_and, nand_and_3in, nand_or and nand_xnor.
- A clocked serial engine wraps the slice. It compares two N-bit operands MSB-first, one bit per enabled cycle, and holds the running greater/equal/less result in registers.
- Used wherever a narrow datapath compares wide values bit-serially, or as a combinational ripple-cascade element.

Parameters:
- N, default 4: number of operand bits consumed per serial comparison (N >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  loads cascade inputs into the state registers and begins a comparison.
- en  input  1  consumes bit (a,b) into the serial state while busy.
- a  input  1  current operand-A bit (MSB first).
- b  input  1  current operand-B bit (MSB first).
- agb_in  input  1  cascade-in: higher-order bits found A>B.
- aeb_in  input  1  cascade-in: higher-order bits equal.
- alb_in  input  1  cascade-in: higher-order bits found A<B.
- agb  output  1  combinational slice result, A>B.
- aeb  output  1  combinational slice result, A=B.
- alb  output  1  combinational slice result, A<B.
- agb_q  output  1  registered serial result, A>B.
- aeb_q  output  1  registered serial result, A=B.
- alb_q  output  1  registered serial result, A<B.
- busy  output  1  serial comparison in progress.
- done  output  1  one-cycle pulse after the Nth bit is consumed.

Behaviour:
- Combinational slice, zero latency, driven from a, b and the *_in inputs:
  - alb = (~a & b & aeb_in) | alb_in
  - aeb = xnor(a,b) & aeb_in
  - agb = (a & ~b & aeb_in) | agb_in
- Slice gate structure:
  - Built exclusively from the NAND primitives.
  - nand_not realises ~a and ~b.
  - nand_and_3in realises each 3-input product term.
  - nand_or merges each product term with its cascade-in.
  - nand_xnor feeds the nand_and that produces aeb.
- Cascade-in combinations are passed through per the equations with no correction. Example: agb_in=1 and alb_in=1 drive both agb=1 and alb=1.
- Serial state: registers g, e, l, bit counter cnt (width ceil(log2(N+1))), busy, done.
- Reset (asynchronous, any time, including mid-comparison) forces:
  - g=0, e=1, l=0
  - cnt=0, busy=0, done=0
- done defaults to 0 on every clock unless set by the last-bit rule below.
- On rising clk edge, priority order:
  - start=1: g,e,l <= agb_in, aeb_in, alb_in; cnt <= 0; busy <= 1. Restarts even if already busy. A simultaneous en is ignored (no bit consumed that cycle).
  - else en=1 and busy=1: g,e,l <= slice equations with the registered g,e,l substituted for agb_in, aeb_in, alb_in. cnt <= cnt+1. If cnt == N-1, then busy <= 0 and done <= 1.
  - else en=1 and busy=0: ignored; state held.
  - else: hold.
- Outputs agb_q, aeb_q, alb_q are g, e, l. They are valid and stable from the cycle done is high until the next start.
- Latency: a result is ready N enabled cycles after start. en gaps stall without losing state.
- With valid one-hot cascade inputs (only aeb_in=1), exactly one of g, e, l is 1 at all times.

Test Plan:
- Slice truth table: alb_in=0, agb_in=0, aeb_in=1.
  - a=1, b=0 -> agb=1, aeb=0, alb=0.
  - a=0, b=1 -> alb=1, others 0.
  - a=1, b=1 -> aeb=1, others 0.
  - a=0, b=0 -> aeb=1, others 0.
- Cascade dominance:
  - agb_in=1, aeb_in=0, a=0, b=1 -> agb=1, aeb=0, alb=0.
  - alb_in=1, aeb_in=0, a=1, b=0 -> alb=1 only.
- Serial compare, N=4, aeb_in=1, cascade others 0, start then 4 en cycles:
  - A=1010 vs B=1001 -> done pulses after 4th bit; agb_q=1, aeb_q=0, alb_q=0.
  - A=0110 vs B=0110 -> aeb_q=1 only.
  - A=0011 vs B=0101 -> alb_q=1 only.
- en stall: same 1010/1001 sequence with en low for 2 cycles mid-stream -> identical result; done delayed 2 cycles; busy held high throughout.
- Reset mid-operation: assert rst after 2 bits -> immediately g=0, e=1, l=0, busy=0, done=0. A new start after rst deassertion produces a correct result.
- Start/en collision: start and en high together -> no bit consumed, cnt=0. A second start while busy reloads cascade inputs and restarts the count.

Source files
------------

// File: rtl/nand_serial_comparator.sv
// -----------------------------------------------------------------------------
// nand_serial_comparator
//
// Purpose:
//   Cascadable 1-bit magnitude-comparator slice built solely from NAND gates,
//   wrapped by a clocked engine that compares two N-bit operands MSB-first,
//   one bit per enabled cycle. The running greater/equal/less result is held
//   in registers and stays valid from the done pulse until the next start.
//
// Ports (top, nand_serial_comparator):
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   start   in   load cascade inputs into g/e/l and begin a comparison
//   en      in   consume the current (a,b) bit while busy
//   a, b    in   current operand bits, MSB first
//   agb_in  in   cascade-in: higher-order bits found A>B
//   aeb_in  in   cascade-in: higher-order bits equal
//   alb_in  in   cascade-in: higher-order bits found A<B
//   agb     out  combinational slice result A>B
//   aeb     out  combinational slice result A=B
//   alb     out  combinational slice result A<B
//   agb_q   out  registered serial result A>B
//   aeb_q   out  registered serial result A=B
//   alb_q   out  registered serial result A<B
//   busy    out  serial comparison in progress
//   done    out  one-cycle pulse after the Nth bit is consumed
//
// Also contains the NAND primitive library (nand2, nand3, nand_not, nand_and,
// nand_and_3in, nand_or, nand_xnor) and the slice (nand_cmp_slice).
// -----------------------------------------------------------------------------

// Leaf 2-input NAND.
module nand2 (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

// Leaf 3-input NAND.
module nand3 (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i & c_i);
endmodule

// Inverter: NAND with both inputs tied together.
module nand_not (
  input  logic a_i,
  output logic y_o
);
  nand2 u_n (.a_i(a_i), .b_i(a_i), .y_o(y_o));
endmodule

// 2-input AND: NAND followed by a NAND inverter.
module nand_and (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic n;
  nand2    u_n   (.a_i(a_i), .b_i(b_i), .y_o(n));
  nand_not u_inv (.a_i(n),   .y_o(y_o));
endmodule

// 3-input AND: 3-input NAND followed by a NAND inverter.
module nand_and_3in (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic y_o
);
  logic n;
  nand3    u_n   (.a_i(a_i), .b_i(b_i), .c_i(c_i), .y_o(n));
  nand_not u_inv (.a_i(n),   .y_o(y_o));
endmodule

// 2-input OR by De Morgan: NAND of the inverted inputs.
module nand_or (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic a_n;
  logic b_n;
  nand_not u_ia (.a_i(a_i), .y_o(a_n));
  nand_not u_ib (.a_i(b_i), .y_o(b_n));
  nand2    u_n  (.a_i(a_n), .b_i(b_n), .y_o(y_o));
endmodule

// XNOR: classic four-NAND XOR followed by a NAND inverter.
module nand_xnor (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic n1;
  logic n2;
  logic n3;
  logic x;
  nand2    u_n1  (.a_i(a_i), .b_i(b_i), .y_o(n1));
  nand2    u_n2  (.a_i(a_i), .b_i(n1),  .y_o(n2));
  nand2    u_n3  (.a_i(b_i), .b_i(n1),  .y_o(n3));
  nand2    u_n4  (.a_i(n2),  .b_i(n3),  .y_o(x));
  nand_not u_inv (.a_i(x),   .y_o(y_o));
endmodule

// One comparator slice. Cascade-in combinations pass straight through the
// equations; an illegal pair such as agb_in=alb_in=1 is not corrected.
module nand_cmp_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic agb_in_i,
  input  logic aeb_in_i,
  input  logic alb_in_i,
  output logic agb_o,
  output logic aeb_o,
  output logic alb_o
);
  logic a_n;
  logic b_n;
  logic gt_term;
  logic lt_term;
  logic eq_bit;

  nand_not     u_not_a (.a_i(a_i), .y_o(a_n));
  nand_not     u_not_b (.a_i(b_i), .y_o(b_n));

  // A>B at this bit only counts if every higher bit was equal.
  nand_and_3in u_gt    (.a_i(a_i), .b_i(b_n), .c_i(aeb_in_i), .y_o(gt_term));
  nand_and_3in u_lt    (.a_i(a_n), .b_i(b_i), .c_i(aeb_in_i), .y_o(lt_term));

  nand_or      u_or_g  (.a_i(gt_term), .b_i(agb_in_i), .y_o(agb_o));
  nand_or      u_or_l  (.a_i(lt_term), .b_i(alb_in_i), .y_o(alb_o));

  nand_xnor    u_xnor  (.a_i(a_i),    .b_i(b_i),      .y_o(eq_bit));
  nand_and     u_and_e (.a_i(eq_bit), .b_i(aeb_in_i), .y_o(aeb_o));
endmodule

// Top level: combinational slice plus the serial engine.
module nand_serial_comparator #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic agb_in,
  input  logic aeb_in,
  input  logic alb_in,
  output logic agb,
  output logic aeb,
  output logic alb,
  output logic agb_q,
  output logic aeb_q,
  output logic alb_q,
  output logic busy,
  output logic done
);

  localparam int              CW       = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          g_q, g_d;
  logic          e_q, e_d;
  logic          l_q, l_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // Serial next-bit result: the same slice with the registered running
  // result standing in for the cascade inputs.
  logic g_nxt;
  logic e_nxt;
  logic l_nxt;

  nand_cmp_slice u_slice (
    .a_i      (a),
    .b_i      (b),
    .agb_in_i (agb_in),
    .aeb_in_i (aeb_in),
    .alb_in_i (alb_in),
    .agb_o    (agb),
    .aeb_o    (aeb),
    .alb_o    (alb)
  );

  nand_cmp_slice u_serial_slice (
    .a_i      (a),
    .b_i      (b),
    .agb_in_i (g_q),
    .aeb_in_i (e_q),
    .alb_in_i (l_q),
    .agb_o    (g_nxt),
    .aeb_o    (e_nxt),
    .alb_o    (l_nxt)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the branches leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (start) begin
      // start wins over en: nothing is consumed on a load cycle.
      g_d     = agb_in;
      e_d     = aeb_in;
      l_d     = alb_in;
      cnt_d   = '0;
      state_d = ST_BUSY;
    end else if (en && (state_q == ST_BUSY)) begin
      g_d   = g_nxt;
      e_d   = e_nxt;
      l_d   = l_nxt;
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= 1'b0;
      e_q     <= 1'b1;
      l_q     <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign agb_q = g_q;
  assign aeb_q = e_q;
  assign alb_q = l_q;
  assign busy  = (state_q == ST_BUSY);
  assign done  = done_q;

endmodule

// File: tb/tb_nand_serial_comparator.sv
// -----------------------------------------------------------------------------
// Testbench for nand_serial_comparator (N = 4).
// Slice vectors come from a table plus random patterns; serial comparisons
// are checked against integer magnitude comparison of the whole operands.
// -----------------------------------------------------------------------------
module tb_nand_serial_comparator;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic en;
  logic a;
  logic b;
  logic agb_in;
  logic aeb_in;
  logic alb_in;
  logic agb;
  logic aeb;
  logic alb;
  logic agb_q;
  logic aeb_q;
  logic alb_q;
  logic busy;
  logic done;

  int n_checks = 0;
  int n_pass   = 0;

  nand_serial_comparator #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .en     (en),
    .a      (a),
    .b      (b),
    .agb_in (agb_in),
    .aeb_in (aeb_in),
    .alb_in (alb_in),
    .agb    (agb),
    .aeb    (aeb),
    .alb    (alb),
    .agb_q  (agb_q),
    .aeb_q  (aeb_q),
    .alb_q  (alb_q),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       b;
    logic       gi;
    logic       ei;
    logic       li;
    logic [2:0] exp_gel;  // {agb, aeb, alb}
  } slice_vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference slice written as magnitude comparison of single bits.
  function automatic logic [2:0] ref_slice(input logic av, input logic bv,
                                           input logic gi, input logic ei,
                                           input logic li);
    int ai = int'(av);
    int bi = int'(bv);
    logic g = gi | (ei & (ai > bi));
    logic e = ei & (ai == bi);
    logic l = li | (ei & (ai < bi));
    return {g, e, l};
  endfunction

  // Reference serial result for one-hot cascade inputs.
  function automatic logic [2:0] ref_serial(input logic [N-1:0] av,
                                            input logic [N-1:0] bv,
                                            input logic gi, input logic li);
    if (gi) return 3'b100;
    if (li) return 3'b001;
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b001;
    return 3'b010;
  endfunction

  // One full serial comparison. gap_len idle (en=0) cycles are inserted
  // before bit gap_at; with rand_gaps each bit gets 0..2 random idle cycles.
  task automatic run_serial(input string name, input logic [N-1:0] av,
                            input logic [N-1:0] bv, input logic gi,
                            input logic ei, input logic li, input int gap_at,
                            input int gap_len, input bit rand_gaps);
    int       cycles    = 0;
    int       gaps      = 0;
    int       bad_state = 0;
    logic [2:0] exp_gel = ref_serial(av, bv, gi, li);
    agb_in = gi; aeb_in = ei; alb_in = li;
    start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int ng = rand_gaps ? int'($urandom_range(0, 2))
                         : ((i == gap_at) ? gap_len : 0);
      for (int k = 0; k < ng; k++) begin
        en = 1'b0;
        a = $urandom_range(0, 1); b = $urandom_range(0, 1);
        tick();
        cycles++; gaps++;
        if (!busy || done) bad_state++;
      end
      en = 1'b1; a = av[i]; b = bv[i];
      tick();
      cycles++;
      if (i != 0 && (!busy || done)) bad_state++;
    end
    en = 1'b0;
    check({name, " busy-held"}, bad_state, 0);
    check({name, " latency"}, cycles, N + gaps);
    check({name, " done"}, {done, busy}, 2'b10);
    check({name, " result"}, {agb_q, aeb_q, alb_q}, exp_gel);
    // Idle en must neither consume a bit nor re-pulse done.
    en = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    en = 1'b0;
    check({name, " hold"}, {agb_q, aeb_q, alb_q, done, busy},
          {exp_gel, 2'b00});
  endtask

  slice_vec_t vecs[6];

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0;
    agb_in = 1'b0; aeb_in = 1'b1; alb_in = 1'b0;
    #2;
    check("reset state", {agb_q, aeb_q, alb_q, busy, done}, 5'b01000);
    #10 rst = 1'b0;

    // ---- Slice table ----
    vecs[0] = '{a: 1, b: 0, gi: 0, ei: 1, li: 0, exp_gel: 3'b100};
    vecs[1] = '{a: 0, b: 1, gi: 0, ei: 1, li: 0, exp_gel: 3'b001};
    vecs[2] = '{a: 1, b: 1, gi: 0, ei: 1, li: 0, exp_gel: 3'b010};
    vecs[3] = '{a: 0, b: 0, gi: 0, ei: 1, li: 0, exp_gel: 3'b010};
    vecs[4] = '{a: 0, b: 1, gi: 1, ei: 0, li: 0, exp_gel: 3'b100};
    vecs[5] = '{a: 1, b: 0, gi: 0, ei: 0, li: 1, exp_gel: 3'b001};
    for (int i = 0; i < 6; i++) begin
      a = vecs[i].a; b = vecs[i].b;
      agb_in = vecs[i].gi; aeb_in = vecs[i].ei; alb_in = vecs[i].li;
      #1;
      check($sformatf("slice vec %0d", i), {agb, aeb, alb}, vecs[i].exp_gel);
    end

    // Both gt and lt cascade-ins pass through uncorrected.
    a = 1'b0; b = 1'b0; agb_in = 1'b1; aeb_in = 1'b0; alb_in = 1'b1;
    #1;
    check("slice gt+lt passthrough", {agb, aeb, alb}, 3'b101);

    // Random slice patterns, including non-one-hot cascade inputs.
    for (int i = 0; i < 24; i++) begin
      logic [4:0] r = 5'($urandom);
      a = r[4]; b = r[3]; agb_in = r[2]; aeb_in = r[1]; alb_in = r[0];
      #1;
      check($sformatf("slice rand %0d", i), {agb, aeb, alb},
            ref_slice(r[4], r[3], r[2], r[1], r[0]));
    end

    // Align to the clock before serial work.
    tick();

    // ---- Serial directed ----
    run_serial("A1010>B1001", 4'b1010, 4'b1001, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
    run_serial("A0110=B0110", 4'b0110, 4'b0110, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
    run_serial("A0011<B0101", 4'b0011, 4'b0101, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
    run_serial("stall 2", 4'b1010, 4'b1001, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0);
    run_serial("cascade gt", 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
    run_serial("cascade lt", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0);

    // ---- Reset mid-operation ----
    agb_in = 1'b0; aeb_in = 1'b1; alb_in = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; a = 1'b1; b = 1'b0; tick();
    a = 1'b0; b = 1'b1; tick();
    en = 1'b0;
    check("pre-reset g set", {agb_q, busy}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async reset mid-op", {agb_q, aeb_q, alb_q, busy, done}, 5'b01000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    en = 1'b1; a = 1'b1; b = 1'b0; tick(); en = 1'b0;
    check("en while idle ignored", {agb_q, aeb_q, alb_q, busy}, 4'b0100);
    run_serial("after reset", 4'b0011, 4'b0101, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0);

    // ---- start/en collision ----
    agb_in = 1'b0; aeb_in = 1'b1; alb_in = 1'b0;
    start = 1'b1; en = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    start = 1'b0;
    check("collision no consume", {agb_q, aeb_q, alb_q, busy}, 4'b0101);
    a = 1'b0; b = 1'b0;
    for (int i = 0; i < N - 1; i++) tick();
    check("collision cnt from 0", {done, busy}, 2'b01);
    tick();
    en = 1'b0;
    check("collision done", {done, busy, aeb_q}, 3'b101);

    // ---- restart while busy ----
    start = 1'b1; tick(); start = 1'b0;
    en = 1'b1; a = 1'b1; b = 1'b0; tick(); tick();
    check("busy before restart", {agb_q, busy}, 2'b11);
    agb_in = 1'b0; aeb_in = 1'b0; alb_in = 1'b1; en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("restart reload", {agb_q, aeb_q, alb_q, busy}, 4'b0011);
    en = 1'b1;
    for (int i = 0; i < N - 1; i++) tick();
    check("restart cnt from 0", {done, busy}, 2'b01);
    tick();
    en = 1'b0;
    check("restart done", {done, busy, agb_q, aeb_q, alb_q}, 5'b10001);

    // ---- Random serial against integer comparison ----
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] av = N'($urandom);
      logic [N-1:0] bv = (t % 4 == 0) ? av : N'($urandom);
      int sel = int'($urandom_range(0, 3));
      run_serial($sformatf("rand %0d", t), av, bv, sel == 1, sel == 0 || sel == 3,
                 sel == 2, -1, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
